// File: rtl/guess_game_seq_if.sv
// Strobe/flag bundle between the round sequencer and the lab 1 guessing datapath.
interface guess_game_seq_if;
  logic o_inc_actual;
  logic o_latch_guess;
  logic o_update_leds;
  logic i_equal;

  modport master (
    output o_inc_actual,
    output o_latch_guess,
    output o_update_leds,
    input  i_equal
  );

  modport slave (
    input  o_inc_actual,
    input  o_latch_guess,
    input  o_update_leds,
    output i_equal
  );
endinterface

// File: rtl/guess_game_seq.sv
// Round sequencer: seeds the target until the first press, paces each guess through
// latch/compare/LED update, counts attempts and holds a timed WIN/LOSE display.
module guess_game_seq #(
  parameter int unsigned MAX_ATTEMPTS = 7,
  parameter int unsigned HOLD_CYCLES  = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_enter,
  guess_game_seq_if.master        dp,
  output logic [3:0]              o_attempts,
  output logic                    o_win,
  output logic                    o_lose
);

  typedef enum logic [2:0] {
    SEED = 3'd0,
    IDLE = 3'd1,
    CMP  = 3'd2,
    WIN  = 3'd3,
    LOSE = 3'd4
  } state_t;

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [3:0]  LAST_TRY  = 4'(MAX_ATTEMPTS);

  state_t      state;
  state_t      state_nxt;
  logic        enter_q;
  logic        press;
  logic [31:0] hold_cnt;
  logic        hold_done;
  logic [3:0]  attempts_nxt;
  logic        in_hold;

  // enter_q resets high so a button held through reset never registers as a press
  assign press        = i_enter & ~enter_q;
  assign hold_done    = (hold_cnt == HOLD_LAST);
  assign attempts_nxt = o_attempts + 4'd1;
  assign in_hold      = (state == WIN) || (state == LOSE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = SEED;
    case (state)
      SEED: state_nxt = press ? IDLE : SEED;
      IDLE: state_nxt = press ? CMP : IDLE;
      CMP: begin
        if (dp.i_equal)
          state_nxt = WIN;
        else if (attempts_nxt == LAST_TRY)
          state_nxt = LOSE;
        else
          state_nxt = IDLE;
      end
      WIN:     state_nxt = hold_done ? SEED : WIN;
      LOSE:    state_nxt = hold_done ? SEED : LOSE;
      default: state_nxt = SEED;
    endcase
  end

  always_comb begin
    dp.o_inc_actual  = 1'b0;
    dp.o_latch_guess = 1'b0;
    dp.o_update_leds = 1'b0;
    o_win            = 1'b0;
    o_lose           = 1'b0;
    case (state)
      SEED:    dp.o_inc_actual  = ~press;
      IDLE:    dp.o_latch_guess = press;
      CMP:     dp.o_update_leds = 1'b1;
      WIN:     o_win            = 1'b1;
      LOSE:    o_lose           = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enter_q    <= 1'b1;
      o_attempts <= '0;
      hold_cnt   <= '0;
    end else begin
      enter_q <= i_enter;

      if (state == CMP)
        o_attempts <= attempts_nxt;
      else if (in_hold && hold_done)
        o_attempts <= '0;

      // Counter idles at zero so it is already cleared on entry to WIN/LOSE
      if (in_hold && !hold_done)
        hold_cnt <= hold_cnt + 32'd1;
      else
        hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_guess_game_seq.sv
// Directed bench for guess_game_seq with MAX_ATTEMPTS=3 and HOLD_CYCLES=4.
module tb_guess_game_seq;

  logic       clk;
  logic       reset;
  logic       i_enter;
  logic [3:0] o_attempts;
  logic       o_win;
  logic       o_lose;

  int checks;
  int errors;

  guess_game_seq_if dp_if ();

  guess_game_seq #(
    .MAX_ATTEMPTS(3),
    .HOLD_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_enter   (i_enter),
    .dp        (dp_if.master),
    .o_attempts(o_attempts),
    .o_win     (o_win),
    .o_lose    (o_lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {inc, latch, upd, win, lose, attempts[3:0]}
  function automatic logic [8:0] outs();
    return {dp_if.o_inc_actual, dp_if.o_latch_guess, dp_if.o_update_leds,
            o_win, o_lose, o_attempts};
  endfunction

  function automatic logic [8:0] ev(input logic inc, input logic lat, input logic upd,
                                    input logic win, input logic lose, input logic [3:0] att);
    return {inc, lat, upd, win, lose, att};
  endfunction

  // Drive inputs just after a rising edge, then sample mid-cycle at the falling edge
  task automatic cyc(input logic enter, input logic equal);
    @(posedge clk);
    #1;
    i_enter       = enter;
    dp_if.i_equal = equal;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] e;
    reset = 1'b1;
    i_enter = 1'b1;
    dp_if.i_equal = 1'b0;
    #2;
    e = ev(1, 0, 0, 0, 0, 4'd0);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL reset_values got %b exp %b", outs(), e);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc(1, 0);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL held_enter_cycle%0d got %b exp %b", i, outs(), e);
      end
    end
  endtask

  // Release/press in SEED; returns in the first IDLE cycle with i_enter low
  task automatic seed_press(input string tag);
    logic [8:0] e;
    cyc(0, 0);
    e = ev(1, 0, 0, 0, 0, 4'd0);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL %s_seed_release got %b exp %b", tag, outs(), e);
    end
    cyc(1, 0);
    e = ev(0, 0, 0, 0, 0, 4'd0);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL %s_seed_press got %b exp %b", tag, outs(), e);
    end
    cyc(0, 0);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL %s_idle_entry got %b exp %b", tag, outs(), e);
    end
  endtask

  // One guess: press cycle in IDLE, then the CMP cycle with i_equal driven
  task automatic guess(input string tag, input logic eq, input logic [3:0] att);
    logic [8:0] e;
    cyc(1, 0);
    e = ev(0, 1, 0, 0, 0, att);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL %s_latch got %b exp %b", tag, outs(), e);
    end
    cyc(0, eq);
    e = ev(0, 0, 1, 0, 0, att);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL %s_cmp got %b exp %b", tag, outs(), e);
    end
  endtask

  task automatic test_first_guess();
    logic [8:0] e;
    seed_press("first");
    guess("first_g1", 1'b0, 4'd0);
    cyc(0, 0);
    e = ev(0, 0, 0, 0, 0, 4'd1);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL first_attempts1 got %b exp %b", outs(), e);
    end
  endtask

  task automatic test_lose();
    logic [8:0] e;
    guess("lose_g2", 1'b0, 4'd1);
    guess("lose_g3", 1'b0, 4'd2);
    e = ev(0, 0, 0, 0, 1, 4'd3);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL lose_hold%0d got %b exp %b", i, outs(), e);
      end
    end
    cyc(0, 0);
    e = ev(1, 0, 0, 0, 0, 4'd0);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL lose_exit got %b exp %b", outs(), e);
    end
  endtask

  task automatic test_win_third();
    logic [8:0] e;
    logic [3:0] pat;
    pat = 4'b1001;
    seed_press("win3");
    guess("win3_g1", 1'b0, 4'd0);
    guess("win3_g2", 1'b0, 4'd1);
    guess("win3_g3", 1'b1, 4'd2);
    e = ev(0, 0, 0, 1, 0, 4'd3);
    for (int i = 0; i < 4; i++) begin
      cyc(pat[i], 0);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL win3_hold%0d got %b exp %b", i, outs(), e);
      end
    end
    // Button still held into SEED: must not count as a press
    cyc(1, 0);
    e = ev(1, 0, 0, 0, 0, 4'd0);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL win3_exit_held got %b exp %b", outs(), e);
    end
  endtask

  task automatic test_win_second();
    logic [8:0] e;
    seed_press("win2");
    guess("win2_g1", 1'b0, 4'd0);
    guess("win2_g2", 1'b1, 4'd1);
    e = ev(0, 0, 0, 1, 0, 4'd2);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL win2_hold%0d got %b exp %b", i, outs(), e);
      end
    end
    cyc(0, 0);
    e = ev(1, 0, 0, 0, 0, 4'd0);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL win2_exit got %b exp %b", outs(), e);
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] e;
    seed_press("arst");
    guess("arst_g1", 1'b0, 4'd0);
    guess("arst_g2", 1'b0, 4'd1);
    #1;
    reset = 1'b1;
    #1;
    e = ev(1, 0, 0, 0, 0, 4'd0);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL arst_immediate got %b exp %b", outs(), e);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_enter = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL arst_after_release got %b exp %b", outs(), e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_guess();
    test_lose();
    test_win_third();
    test_win_second();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
